// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: load-size codes, FSM states and
// the load alignment rule used by load_align.
package wb_pkg;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // A load must sit on its natural boundary; a dword never fits a 32-bit datapath.
  function automatic logic ld_misaligned(input logic [1:0] ldsize,
                                         input logic [2:0] off,
                                         input logic       narrow);
    case (ldsize)
      LD_H:    return off[0];
      LD_W:    return off[1:0] != 2'b00;
      LD_D:    return narrow || (off != 3'b000);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/half/word/dword out of
// a little-endian memory word and sign- or zero-extends it to the datapath width.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [1:0]        ldsize,
  input  logic              ldsign,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] word_ext;
  logic [2:0]        off3;

  assign shifted = raw >> {addr_lo, 3'b000};
  assign off3    = 3'(addr_lo);

  // On a 32-bit datapath a word already fills the register, so ldsign has no effect.
  if (DATA_W == 64) begin : g_word64
    assign word_ext = {{32{ldsign & shifted[31]}}, shifted[31:0]};
  end else begin : g_word32
    assign word_ext = shifted;
  end

  always_comb begin
    data = raw;
    case (ldsize)
      LD_B:    data = {{(DATA_W-8){ldsign & shifted[7]}}, shifted[7:0]};
      LD_H:    data = {{(DATA_W-16){ldsign & shifted[15]}}, shifted[15:0]};
      LD_W:    data = word_ext;
      default: data = raw;
    endcase
  end

  assign err = ld_misaligned(ldsize, off3, DATA_W == 32);

endmodule

// File: rtl/wb_pipe.sv
// Write-back stage: accepts one instruction from MEM, waits for load data when
// needed, and issues a single register-file write (or a load error) per instruction.
module wb_pipe
  import wb_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  RA_W      = 5,
  parameter int  ZERO_LOCK = 1,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [1:0]        in_ldsize,
  input  logic              in_ldsign,
  input  logic [OFF_W-1:0]  in_addr_lo,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ld_err,
  output logic              busy
);

  state_t state_q, state_d;

  logic              memtoreg_q;
  logic              regwrite_q;
  logic [1:0]        ldsize_q;
  logic              ldsign_q;
  logic [OFF_W-1:0]  addr_lo_q;
  logic [DATA_W-1:0] aluout_q;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] rdata_q;
  logic [RA_W-1:0]   waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              handshake;
  logic              in_write;
  logic              ld_fault;
  logic              align_err;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] new_wdata;

  // Acceptance is only possible in IDLE or WRITE; flush and reset both veto it.
  assign in_ready  = !reset && !flush && (state_q == IDLE || state_q == WRITE);
  assign handshake = in_valid && in_ready;

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .raw     (rdata_q),
    .addr_lo (addr_lo_q),
    .ldsize  (ldsize_q),
    .ldsign  (ldsign_q),
    .data    (ld_data),
    .err     (align_err)
  );

  assign ld_fault  = memtoreg_q && align_err;
  assign new_wdata = memtoreg_q ? ld_data : aluout_q;
  assign in_write  = (state_q == WRITE) && !reset && !flush;

  assign ld_err   = in_write && ld_fault;
  assign rf_we    = in_write && regwrite_q && !ld_fault &&
                    ((ZERO_LOCK == 0) || (rd_q != '0));
  assign rf_waddr = rf_we ? rd_q : waddr_q;
  assign rf_wdata = rf_we ? new_wdata : wdata_q;
  assign busy     = !reset && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake) state_d = in_memtoreg ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        // A flush that coincides with the data needs no drain; the data is simply dropped.
        if (flush)           state_d = mem_rvalid ? IDLE : DRAIN;
        else if (mem_rvalid) state_d = WRITE;
      end
      WRITE: begin
        if (handshake) state_d = in_memtoreg ? WAIT_MEM : WRITE;
        else           state_d = IDLE;
      end
      DRAIN: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        memtoreg_q <= in_memtoreg;
        regwrite_q <= in_regwrite;
      end
      if (rf_we) begin
        waddr_q <= rd_q;
        wdata_q <= new_wdata;
      end
    end
  end

  // Datapath captures need no reset: they are only observed after a handshake.
  always_ff @(posedge clk) begin
    if (handshake) begin
      ldsize_q  <= in_ldsize;
      ldsign_q  <= in_ldsign;
      addr_lo_q <= in_addr_lo;
      aluout_q  <= in_aluout;
      rd_q      <= in_rd;
    end
    if (!reset && state_q == WAIT_MEM && mem_rvalid && !flush) begin
      rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench: a 32-bit (ZERO_LOCK=1) and a 64-bit (ZERO_LOCK=0) wb_pipe
// share one stimulus stream and are checked against a behavioural load model.
module tb_wb_pipe;
  import wb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_memtoreg, in_regwrite, in_ldsign, mem_rvalid, flush;
  logic [1:0]  in_ldsize;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_aluout, mem_rdata;
  logic [4:0]  in_rd;

  logic        rdy_a, we_a, err_a, busy_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic        rdy_b, we_b, err_b, busy_b;
  logic [4:0]  waddr_b;
  logic [63:0] wdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  last_addr_a, last_addr_b;
  logic [31:0] last_data_a;
  logic [63:0] last_data_b;

  wb_pipe #(.DATA_W(32), .RA_W(5), .ZERO_LOCK(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_ldsize(in_ldsize),
    .in_ldsign(in_ldsign), .in_addr_lo(in_addr_lo[1:0]), .in_aluout(in_aluout[31:0]),
    .in_rd(in_rd), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .flush(flush),
    .rf_we(we_a), .rf_waddr(waddr_a), .rf_wdata(wdata_a), .ld_err(err_a), .busy(busy_a)
  );

  wb_pipe #(.DATA_W(64), .RA_W(5), .ZERO_LOCK(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_ldsize(in_ldsize),
    .in_ldsign(in_ldsign), .in_addr_lo(in_addr_lo), .in_aluout(in_aluout),
    .in_rd(in_rd), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .rf_we(we_b), .rf_waddr(waddr_b), .rf_wdata(wdata_b), .ld_err(err_b), .busy(busy_b)
  );

  // Expected register value of a load: bytes taken little-endian from offset
  // 'off', then extended; widths that already fill the register are not extended.
  function automatic logic [63:0] model_load(input int dw, input logic [63:0] raw_in,
                                             input int off, input int size, input bit sgn,
                                             output bit err);
    int nb;
    logic [63:0] raw, v, mask;
    nb   = 1 << size;
    err  = (dw == 32 && size == 3) || (off % nb != 0);
    raw  = (dw == 32) ? (raw_in & 64'hFFFF_FFFF) : raw_in;
    if (nb * 8 >= dw) return raw >> (off * 8);
    mask = (64'd1 << (nb * 8)) - 64'd1;
    v    = (raw >> (off * 8)) & mask;
    if (sgn && v[nb*8-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    in_valid = 0; flush = 0; mem_rvalid = 0; in_memtoreg = 0; in_regwrite = 0;
    in_ldsize = 0; in_ldsign = 0; in_addr_lo = 0; in_aluout = 0; in_rd = 0; mem_rdata = 0;
  endtask

  task automatic drive_op(input bit m, input bit rw, input logic [1:0] sz, input bit sg,
                          input logic [2:0] off, input logic [63:0] alu, input logic [4:0] rd);
    in_valid = 1; in_memtoreg = m; in_regwrite = rw; in_ldsize = sz; in_ldsign = sg;
    in_addr_lo = off; in_aluout = alu; in_rd = rd;
  endtask

  task automatic test_reset();
    reset = 1;
    drive_idle();
    tick();
    tick();
    settle();
    n_cmp++;
    if ({we_a, err_a, busy_a, rdy_a, we_b, err_b, busy_b, rdy_b} !== 8'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: we/err/busy/rdy a=%b%b%b%b b=%b%b%b%b, expected all 0",
               we_a, err_a, busy_a, rdy_a, we_b, err_b, busy_b, rdy_b);
    end
    tick();
    reset = 0;
    settle();
    n_cmp++;
    if (waddr_a !== 5'd0 || wdata_a !== 32'd0 || waddr_b !== 5'd0 || wdata_b !== 64'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_regs: a=%0d/%h b=%0d/%h, expected 0/0", waddr_a, wdata_a, waddr_b, wdata_b);
    end
    n_cmp++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_ready: rdy=%b%b busy=%b%b, expected rdy=11 busy=00", rdy_a, rdy_b, busy_a, busy_b);
    end
    last_addr_a = 0; last_data_a = 0; last_addr_b = 0; last_data_b = 0;
    tick();
  endtask

  task automatic test_alu();
    drive_op(0, 1, LD_W, 0, 0, 64'h1234, 5'd3);
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (we_a !== 1'b1 || waddr_a !== 5'd3 || wdata_a !== 32'h1234 || err_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL alu32: we=%b waddr=%0d wdata=%h err=%b, expected 1/3/00001234/0", we_a, waddr_a, wdata_a, err_a);
    end
    n_cmp++;
    if (we_b !== 1'b1 || waddr_b !== 5'd3 || wdata_b !== 64'h1234) begin
      n_bad++;
      $display("[TB] FAIL alu64: we=%b waddr=%0d wdata=%h, expected 1/3/1234", we_b, waddr_b, wdata_b);
    end
    tick();
    settle();
    n_cmp++;
    if (we_a !== 1'b0 || waddr_a !== 5'd3 || wdata_a !== 32'h1234 || busy_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL alu_hold: we=%b waddr=%0d wdata=%h busy=%b, expected 0/3/00001234/0", we_a, waddr_a, wdata_a, busy_a);
    end
    last_addr_a = 3; last_data_a = 32'h1234; last_addr_b = 3; last_data_b = 64'h1234;
  endtask

  task automatic test_lb();
    drive_op(1, 1, LD_B, 1, 3'd2, 64'hDEAD, 5'd7);
    tick();
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || busy_a !== 1'b1 || we_a !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL lb_wait%0d: rdy=%b%b busy=%b we=%b, expected rdy=00 busy=1 we=0", c, rdy_a, rdy_b, busy_a, we_a);
      end
      tick();
    end
    mem_rvalid = 1;
    mem_rdata  = 64'h0080_0000;
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (we_a !== 1'b1 || waddr_a !== 5'd7 || wdata_a !== 32'hFFFF_FF80) begin
      n_bad++;
      $display("[TB] FAIL lb32: we=%b waddr=%0d wdata=%h, expected 1/7/ffffff80", we_a, waddr_a, wdata_a);
    end
    n_cmp++;
    if (we_b !== 1'b1 || waddr_b !== 5'd7 || wdata_b !== 64'hFFFF_FFFF_FFFF_FF80) begin
      n_bad++;
      $display("[TB] FAIL lb64: we=%b waddr=%0d wdata=%h, expected 1/7/ffffffffffffff80", we_b, waddr_b, wdata_b);
    end
    last_addr_a = 7; last_data_a = 32'hFFFF_FF80; last_addr_b = 7; last_data_b = 64'hFFFF_FFFF_FFFF_FF80;
    tick();
  endtask

  task automatic test_misaligned();
    drive_op(1, 1, LD_H, 0, 3'd1, 64'h0, 5'd9);
    tick();
    drive_idle();
    mem_rvalid = 1;
    mem_rdata  = 64'h1234_5678_9ABC_DEF0;
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (err_a !== 1'b1 || we_a !== 1'b0 || err_b !== 1'b1 || we_b !== 1'b0 || waddr_a !== last_addr_a) begin
      n_bad++;
      $display("[TB] FAIL lhu_misaligned: err=%b%b we=%b%b waddr=%0d, expected err=11 we=00 waddr=%0d",
               err_a, err_b, we_a, we_b, waddr_a, last_addr_a);
    end
    tick();
    settle();
    n_cmp++;
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL err_pulse: err=%b%b one cycle later, expected 00", err_a, err_b);
    end
    drive_op(1, 1, LD_D, 0, 3'd0, 64'h0, 5'd10);
    tick();
    drive_idle();
    mem_rvalid = 1;
    mem_rdata  = 64'hFEDC_BA98_7654_3210;
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (we_b !== 1'b1 || waddr_b !== 5'd10 || wdata_b !== 64'hFEDC_BA98_7654_3210 || err_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ld64: we=%b waddr=%0d wdata=%h err=%b, expected 1/10/fedcba9876543210/0", we_b, waddr_b, wdata_b, err_b);
    end
    n_cmp++;
    if (we_a !== 1'b0 || err_a !== 1'b1 || wdata_a !== last_data_a) begin
      n_bad++;
      $display("[TB] FAIL ld_on_32: we=%b err=%b wdata=%h, expected 0/1/%h", we_a, err_a, wdata_a, last_data_a);
    end
    last_addr_b = 10; last_data_b = 64'hFEDC_BA98_7654_3210;
    tick();
  endtask

  task automatic test_flush_wait();
    drive_op(1, 1, LD_W, 0, 3'd0, 64'h0, 5'd11);
    tick();
    drive_idle();
    tick();
    flush = 1;
    settle();
    n_cmp++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL flush_wait_state: rdy=%b busy=%b, expected 0/1", rdy_a, busy_a);
    end
    tick();
    flush = 0;
    settle();
    n_cmp++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || rdy_a !== 1'b0 || we_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL drain_wait: busy=%b%b rdy=%b we=%b, expected 11/0/0", busy_a, busy_b, rdy_a, we_a);
    end
    tick();
    mem_rvalid = 1;
    mem_rdata  = 64'hAAAA_5555_AAAA_5555;
    settle();
    n_cmp++;
    if (busy_a !== 1'b1 || we_a !== 1'b0 || we_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL drain_rvalid: busy=%b we=%b%b, expected busy=1 we=00", busy_a, we_a, we_b);
    end
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || we_a !== 1'b0 || we_b !== 1'b0 || wdata_b !== last_data_b) begin
      n_bad++;
      $display("[TB] FAIL drain_done: busy=%b%b we=%b%b wdata_b=%h, expected busy=00 we=00 wdata_b=%h",
               busy_a, busy_b, we_a, we_b, wdata_b, last_data_b);
    end
    tick();
  endtask

  task automatic test_flush_idle_write();
    drive_op(0, 1, LD_W, 0, 3'd0, 64'h55, 5'd12);
    flush = 1;
    settle();
    n_cmp++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL flush_idle_ready: rdy=%b%b, expected 00", rdy_a, rdy_b);
    end
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (busy_a !== 1'b0 || we_a !== 1'b0 || we_b !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL flush_idle_accept: busy=%b we=%b%b, expected 0/00", busy_a, we_a, we_b);
    end
    drive_op(0, 1, LD_W, 0, 3'd0, 64'h66, 5'd13);
    tick();
    drive_idle();
    flush = 1;
    settle();
    n_cmp++;
    if (we_a !== 1'b0 || we_b !== 1'b0 || waddr_a !== last_addr_a || wdata_b !== last_data_b) begin
      n_bad++;
      $display("[TB] FAIL flush_write: we=%b%b waddr_a=%0d wdata_b=%h, expected 00/%0d/%h",
               we_a, we_b, waddr_a, wdata_b, last_addr_a, last_data_b);
    end
    tick();
    flush = 0;
    settle();
    n_cmp++;
    if (busy_a !== 1'b0 || we_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL flush_write_after: busy=%b we=%b, expected 0/0", busy_a, we_a);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int writes_a;
    bit exp_we_a;
    writes_a = 0;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive_op(0, 1, LD_W, 0, 3'd0, 64'(100 + c), 5'(c));
      else drive_idle();
      settle();
      if (c < 4) begin
        n_cmp++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL b2b_ready%0d: rdy=%b%b, expected 11", c, rdy_a, rdy_b);
        end
      end
      exp_we_a = (c >= 2);
      n_cmp++;
      if (we_a !== exp_we_a || (exp_we_a && (waddr_a !== 5'(c - 1) || wdata_a !== 32'(99 + c)))) begin
        n_bad++;
        $display("[TB] FAIL b2b32_cycle%0d: we=%b waddr=%0d wdata=%0d, expected we=%b waddr=%0d wdata=%0d",
                 c, we_a, waddr_a, wdata_a, exp_we_a, c - 1, 99 + c);
      end
      n_cmp++;
      if (we_b !== (c >= 1) || (c >= 1 && (waddr_b !== 5'(c - 1) || wdata_b !== 64'(99 + c)))) begin
        n_bad++;
        $display("[TB] FAIL b2b64_cycle%0d: we=%b waddr=%0d wdata=%0d, expected we=%b waddr=%0d wdata=%0d",
                 c, we_b, waddr_b, wdata_b, c >= 1, c - 1, 99 + c);
      end
      if (we_a === 1'b1) writes_a++;
      tick();
    end
    n_cmp++;
    if (writes_a != 3) begin
      n_bad++;
      $display("[TB] FAIL b2b_count: writes=%0d, expected 3", writes_a);
    end
    last_addr_a = 3; last_data_a = 103; last_addr_b = 3; last_data_b = 103;
  endtask

  task automatic test_reset_wait();
    drive_op(1, 1, LD_W, 0, 3'd0, 64'h0, 5'd14);
    tick();
    drive_idle();
    tick();
    reset = 1;
    settle();
    n_cmp++;
    if (we_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_in_wait: we=%b busy=%b rdy=%b, expected 0/0/0", we_a, busy_a, rdy_a);
    end
    tick();
    reset = 0;
    mem_rvalid = 1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    settle();
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || rdy_a !== 1'b1 || waddr_a !== 5'd0 || wdata_b !== 64'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_late_rvalid: busy=%b%b rdy=%b waddr=%0d wdata_b=%h, expected 00/1/0/0",
               busy_a, busy_b, rdy_a, waddr_a, wdata_b);
    end
    tick();
    mem_rvalid = 0;
    settle();
    n_cmp++;
    if (we_a !== 1'b0 || we_b !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_no_write: we=%b%b busy=%b, expected 00/0", we_a, we_b, busy_a);
    end
    reset = 1;
    tick();
    reset = 0;
    drive_op(0, 1, LD_W, 0, 3'd0, 64'h77, 5'd15);
    tick();
    drive_idle();
    settle();
    n_cmp++;
    if (we_a !== 1'b1 || waddr_a !== 5'd15 || wdata_a !== 32'h77) begin
      n_bad++;
      $display("[TB] FAIL first_after_reset: we=%b waddr=%0d wdata=%h, expected 1/15/00000077", we_a, waddr_a, wdata_a);
    end
    last_addr_a = 15; last_data_a = 32'h77; last_addr_b = 15; last_data_b = 64'h77;
    tick();
  endtask

  task automatic test_random();
    bit m, rw, sg, ea, eb, xwe_a, xwe_b;
    int sz, off, lat;
    logic [4:0]  rd, xaddr_a, xaddr_b;
    logic [63:0] alu, raw, va, vb, xdata_b;
    logic [31:0] xdata_a;
    for (int i = 0; i < 60; i++) begin
      m   = 1'($urandom_range(0, 1));
      rw  = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 31));
      sz  = $urandom_range(0, 3);
      sg  = 1'($urandom_range(0, 1));
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 2) != 0) off = off & ~((1 << sz) - 1);
      alu = {$urandom, $urandom};
      raw = {$urandom, $urandom};
      drive_op(m, rw, 2'(sz), sg, 3'(off), alu, rd);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = {$urandom, $urandom};
      settle();
      n_cmp++;
      if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL rnd%0d_ready: rdy=%b%b, expected 11", i, rdy_a, rdy_b);
      end
      tick();
      in_valid = 0; in_rd = 5'($urandom); in_aluout = {$urandom, $urandom};
      in_memtoreg = 1'($urandom); in_regwrite = 1'($urandom); in_ldsize = 2'($urandom);
      in_ldsign = 1'($urandom); in_addr_lo = 3'($urandom);
      if (m) begin
        lat = $urandom_range(0, 3);
        for (int c = 0; c < lat; c++) begin
          mem_rvalid = 0;
          settle();
          n_cmp++;
          if (busy_a !== 1'b1 || rdy_a !== 1'b0 || we_a !== 1'b0 || we_b !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rnd%0d_wait: busy=%b rdy=%b we=%b%b, expected 1/0/00", i, busy_a, rdy_a, we_a, we_b);
          end
          tick();
        end
        mem_rvalid = 1;
        mem_rdata  = raw;
        tick();
        va = model_load(32, raw, off & 3, sz, sg, ea);
        vb = model_load(64, raw, off, sz, sg, eb);
      end else begin
        va = alu; vb = alu; ea = 0; eb = 0;
      end
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = {$urandom, $urandom};
      xwe_a   = rw && !ea && (rd != 5'd0);
      xwe_b   = rw && !eb;
      xaddr_a = xwe_a ? rd : last_addr_a;
      xdata_a = xwe_a ? va[31:0] : last_data_a;
      xaddr_b = xwe_b ? rd : last_addr_b;
      xdata_b = xwe_b ? vb : last_data_b;
      settle();
      n_cmp++;
      if (we_a !== xwe_a || err_a !== ea || waddr_a !== xaddr_a || wdata_a !== xdata_a) begin
        n_bad++;
        $display("[TB] FAIL rnd%0d_write32: we=%b err=%b waddr=%0d wdata=%h, expected %b/%b/%0d/%h",
                 i, we_a, err_a, waddr_a, wdata_a, xwe_a, ea, xaddr_a, xdata_a);
      end
      n_cmp++;
      if (we_b !== xwe_b || err_b !== eb || waddr_b !== xaddr_b || wdata_b !== xdata_b) begin
        n_bad++;
        $display("[TB] FAIL rnd%0d_write64: we=%b err=%b waddr=%0d wdata=%h, expected %b/%b/%0d/%h",
                 i, we_b, err_b, waddr_b, wdata_b, xwe_b, eb, xaddr_b, xdata_b);
      end
      last_addr_a = xaddr_a; last_data_a = xdata_a; last_addr_b = xaddr_b; last_data_b = xdata_b;
      tick();
      mem_rvalid = 1'($urandom_range(0, 1));
      settle();
      n_cmp++;
      if (we_a !== 1'b0 || we_b !== 1'b0 || busy_a !== 1'b0 || waddr_a !== last_addr_a ||
          wdata_a !== last_data_a || wdata_b !== last_data_b) begin
        n_bad++;
        $display("[TB] FAIL rnd%0d_hold: we=%b%b busy=%b waddr=%0d wdata=%h/%h, expected 00/0/%0d/%h/%h",
                 i, we_a, we_b, busy_a, waddr_a, wdata_a, wdata_b, last_addr_a, last_data_a, last_data_b);
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_misaligned();
    test_flush_wait();
    test_flush_idle_write();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, register/data width; legal values 32 and 64 only.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter ZERO_LOCK, default 1; when 1, writes to register 0 are suppressed.
REQ-004 Derived constant OFF_W = log2(DATA_W/8): 2 when DATA_W=32, 3 when DATA_W=64.
REQ-005 Port list, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  wb_pipe accepts this cycle.
- in_memtoreg  in  1  1 = write load data; 0 = write in_aluout.
- in_regwrite  in  1  instruction writes the register file.
- in_ldsize  in  2  0 byte, 1 half, 2 word, 3 dword.
- in_ldsign  in  1  1 = sign-extend; 0 = zero-extend.
- in_addr_lo  in  OFF_W  low address bits of the load.
- in_aluout  in  DATA_W  ALU result.
- in_rd  in  RA_W  destination register.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  raw memory word, little-endian.
- flush  in  1  cancel the held instruction.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  DATA_W  write data.
- ld_err  out  1  one-cycle pulse on a misaligned or illegal load.
- busy  out  1  state is not IDLE.

Function
REQ-006 The FSM SHALL have four states: IDLE, WAIT_MEM, WRITE and DRAIN.
REQ-007 A handshake occurs when in_valid and in_ready are both 1; all in_* fields SHALL be captured on that edge.
REQ-008 in_ready SHALL be 1 in IDLE and WRITE, and 0 in WAIT_MEM and DRAIN.
REQ-009 Transitions on a handshake: in_memtoreg=1 goes to WAIT_MEM; in_memtoreg=0 goes to WRITE.
REQ-010 WAIT_MEM SHALL move to WRITE on the first mem_rvalid=1 and SHALL capture mem_rdata on that edge; mem_rvalid SHALL be ignored in IDLE and WRITE.
REQ-011 WRITE SHALL last exactly one cycle, then go to IDLE, or follow REQ-009 if a new handshake occurs in that cycle.
REQ-012 rf_we SHALL be 1 only in WRITE, when the captured regwrite=1, no error is flagged, and (ZERO_LOCK=0 or rd!=0).
REQ-013 Latency: for a non-load accepted at edge N, rf_we SHALL be high in cycle N+1.
REQ-014 Latency: for a load whose mem_rvalid is sampled at edge M, rf_we SHALL be high in cycle M+1.
REQ-015 Sustained throughput for back-to-back non-loads SHALL be one instruction per cycle.
REQ-016 Load data: extract the byte, half, word or dword at in_addr_lo*8, then sign- or zero-extend it to DATA_W per in_ldsign.
- dword SHALL use the full word.
- Word loads with DATA_W=32 SHALL ignore in_ldsign.
REQ-017 Error cases:
- half with addr_lo[0]!=0;
- word with addr_lo[1:0]!=0;
- dword with addr_lo!=0;
- dword when DATA_W=32.
REQ-018 On an error case: ld_err SHALL pulse in the WRITE cycle and no register write SHALL occur.
REQ-019 flush in WRITE SHALL suppress rf_we; flush takes priority over a write.
REQ-020 flush in WAIT_MEM SHALL go to DRAIN; DRAIN waits for mem_rvalid, discards the data, then goes to IDLE.
REQ-021 flush in IDLE, or flush coincident with a handshake, SHALL block acceptance of that instruction; in_ready SHALL be 0 while flush=1.
REQ-022 rf_waddr and rf_wdata SHALL hold their last value when rf_we=0.

Reset
REQ-023 reset SHALL force the FSM to IDLE and clear rf_we, ld_err and busy.
REQ-024 reset SHALL set rf_waddr and rf_wdata to 0 and discard any pending load; reset has priority over all other inputs.
REQ-025 The first handshake after reset SHALL be possible in the first cycle reset is low.

Structure
REQ-026 Package wb_pkg SHALL hold the ldsize encodings (LD_B, LD_H, LD_W, LD_D) and the state enum.
REQ-027 The extraction and extension logic SHALL be a combinational sub-module named load_align, instantiated once.

Verification
REQ-028 The bench SHALL cover these scenarios (DATA_W=32 unless stated):
- ALU op, rd=3, aluout=0x1234 -> rf_we=1 next cycle, waddr=3, wdata=0x1234.
- lb signed, addr_lo=2, rdata=0x00800000, rvalid 3 cycles after accept -> wdata=0xFFFFFF80 one cycle after rvalid; in_ready=0 while waiting.
- lhu, addr_lo=1 -> ld_err pulse, no rf_we; ld with DATA_W=64, addr_lo=0 -> full 64-bit write.
- Flush during WAIT_MEM, rvalid 2 cycles later -> no rf_we, busy falls the cycle after rvalid.
- 4 back-to-back ALU ops (rd=0,1,2,3) with ZERO_LOCK=1 -> 3 writes on consecutive cycles, none to r0.
- reset asserted in WAIT_MEM, then a late rvalid -> no write, state IDLE.
